fpnew_cast_out_buffer: RTL and testbench

Output stage placed directly downstream of the float-to-float cast unit. It registers the cast result, status flags, NaN-box extension bit and tag behind a full-throughput 2-entry skid buffer, so a stalled consumer never combinationally back-pressures the cast datapath. It also keeps a sticky accumulation of the IEEE status flags of every result that retires, for the FP CSR.

---
 rtl/fpnew_cast_out_buffer.sv | 128 ++++++++++++
 tb/tb_fpnew_cast_out_buffer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fpnew_cast_out_buffer.sv
// fpnew_cast_out_buffer
// Output stage behind the float-to-float cast unit. Registers the cast
// result, status flags, NaN-box extension bit and tag behind a full-throughput
// 2-entry skid buffer. A stalled consumer therefore never back-pressures the
// cast datapath combinationally. It also keeps a sticky OR of the status of
// every retired result for the FP CSR.
//
// Ports
//   clk_i, rst_i          : clock, synchronous active-high reset
//   result_i/status_i/extension_bit_i/tag_i/in_valid_i -> in_ready_o : upstream
//   result_o/status_o/extension_bit_o/tag_o/out_valid_o <- out_ready_i : downstream
//   flush_i               : drop every buffered result (no retirement)
//   clear_flags_i         : clear accumulated flags (a same-cycle pop survives)
//   fflags_o              : sticky flags {NV,DZ,OF,UF,NX}
//   busy_o                : at least one entry held
module fpnew_cast_out_buffer #(
  parameter int unsigned DstWidth = 32,
  parameter type         TagType  = logic
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [DstWidth-1:0] result_i,
  input  logic [4:0]          status_i,
  input  logic                extension_bit_i,
  input  TagType              tag_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                flush_i,
  output logic [DstWidth-1:0] result_o,
  output logic [4:0]          status_o,
  output logic                extension_bit_o,
  output TagType              tag_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  input  logic                clear_flags_i,
  output logic [4:0]          fflags_o,
  output logic                busy_o
);

  typedef struct packed {
    logic [DstWidth-1:0] result;
    logic [4:0]          status;
    logic                ext;
    TagType              tag;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e state_q, state_d;
  entry_t main_q, skid_q, in_entry;
  logic   push, pop;
  logic   load_main, load_skid, skid_to_main;
  logic [4:0] fflags_q;

  assign in_entry = '{result: result_i, status: status_i, ext: extension_bit_i, tag: tag_i};

  // Ready comes from registered state only; reset gating is the single
  // combinational input-to-output path.
  assign in_ready_o  = (state_q != FULL) & ~rst_i;
  assign out_valid_o = (state_q != EMPTY);
  assign busy_o      = (state_q != EMPTY);

  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;

  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state_q)
      EMPTY: if (push) begin
        load_main = 1'b1;
        state_d   = ONE;
      end
      ONE: begin
        if (push && pop) begin
          load_main = 1'b1;
        end else if (push) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: if (pop) begin
        skid_to_main = 1'b1;
        state_d      = ONE;
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins over everything; data loads are suppressed so nothing
    // from the flush cycle lingers in storage.
    if (flush_i) begin
      state_d      = EMPTY;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= EMPTY;
      fflags_q <= '0;
    end else begin
      state_q  <= state_d;
      // Clear applies before the OR so a status popped in the clear cycle
      // is kept.
      fflags_q <= (clear_flags_i ? 5'b0 : fflags_q)
                | ((pop & ~flush_i) ? main_q.status : 5'b0);
    end
  end

  // Payload storage is left unreset; validity is tracked by state_q.
  always_ff @(posedge clk_i) begin
    if (load_main)         main_q <= in_entry;
    else if (skid_to_main) main_q <= skid_q;
    if (load_skid)         skid_q <= in_entry;
  end

  assign result_o        = main_q.result;
  assign status_o        = main_q.status;
  assign extension_bit_o = main_q.ext;
  assign tag_o           = main_q.tag;
  assign fflags_o        = fflags_q;

endmodule

// File: tb/tb_fpnew_cast_out_buffer.sv
// Bench for fpnew_cast_out_buffer: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based model of a depth-2 FIFO with
// sticky flag accumulation.
module tb_fpnew_cast_out_buffer;
  typedef logic [3:0] tag_t;
  typedef struct {
    logic [31:0] r;
    logic [4:0]  s;
    logic        e;
    tag_t        t;
  } ent_t;

  logic        clk = 0;
  logic        rst;
  logic [31:0] result_i;
  logic [4:0]  status_i;
  logic        ext_i;
  tag_t        tag_i;
  logic        in_valid, in_ready, flush, out_valid, out_ready, clear, busy;
  logic [31:0] result_o;
  logic [4:0]  status_o, fflags;
  logic        ext_o;
  tag_t        tag_o;

  int vec = 0;
  int err = 0;
  ent_t q[$];
  logic [4:0] ff_m = '0;

  always #5 clk = ~clk;

  fpnew_cast_out_buffer #(.DstWidth(32), .TagType(tag_t)) dut (
    .clk_i(clk), .rst_i(rst),
    .result_i(result_i), .status_i(status_i), .extension_bit_i(ext_i), .tag_i(tag_i),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .flush_i(flush),
    .result_o(result_o), .status_o(status_o), .extension_bit_o(ext_o), .tag_o(tag_o),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .clear_flags_i(clear), .fflags_o(fflags), .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    if (obs !== exp) begin
      err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] s,
                       input logic e, input tag_t t);
    in_valid = v; result_i = r; status_i = s; ext_i = e; tag_i = t;
  endtask

  // Check outputs against the model mid-cycle, then advance the model on the
  // edge using the same (stable) inputs.
  task automatic cycle();
    logic pu, po;
    ent_t e;
    @(negedge clk);
    chk("in_ready", {63'b0, in_ready}, {63'b0, (!rst && q.size() < 2)});
    chk("out_valid", {63'b0, out_valid}, {63'b0, q.size() > 0});
    chk("busy", {63'b0, busy}, {63'b0, q.size() > 0});
    chk("fflags", {59'b0, fflags}, {59'b0, ff_m});
    if (q.size() > 0)
      chk("head", {22'b0, result_o, status_o, ext_o, tag_o},
                  {22'b0, q[0].r, q[0].s, q[0].e, q[0].t});
    @(posedge clk);
    if (rst) begin
      q.delete();
      ff_m = '0;
    end else begin
      pu = in_valid && q.size() < 2;
      po = out_ready && q.size() > 0;
      if (flush) begin
        ff_m = clear ? 5'b0 : ff_m;
        q.delete();
      end else begin
        ff_m = (clear ? 5'b0 : ff_m) | (po ? q[0].s : 5'b0);
        if (po) void'(q.pop_front());
        if (pu) begin
          e.r = result_i; e.s = status_i; e.e = ext_i; e.t = tag_i;
          q.push_back(e);
        end
      end
    end
    #1;
  endtask

  initial begin
    rst = 1; flush = 0; clear = 0; out_ready = 0;
    drive(0, '0, '0, 0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_fflags", {59'b0, fflags}, 64'd0);
    rst = 0;
    #1;
    chk("rst_rel_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_busy", {63'b0, busy}, 64'd0);

    // Streaming
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h3F800000 + i, 5'b0, i[0], tag_t'(i));
      cycle();
      chk("stream_res", {32'b0, result_o}, {32'b0, 32'h3F800000 + i});
      chk("stream_tag", {60'b0, tag_o}, {60'b0, tag_t'(i)});
      chk("stream_rdy", {63'b0, in_ready}, 64'd1);
    end
    drive(0, '0, '0, 0, '0);
    cycle();

    // Stall / skid
    out_ready = 0;
    drive(1, 32'h40000000, 5'b0, 0, 4'd1); cycle();
    drive(1, 32'h40400000, 5'b0, 0, 4'd2); cycle();
    chk("stall_rdy", {63'b0, in_ready}, 64'd0);
    chk("stall_head", {32'b0, result_o}, 64'h40000000);
    drive(0, '0, '0, 0, '0); cycle();
    chk("stall_head2", {32'b0, result_o}, 64'h40000000);
    out_ready = 1; cycle();
    chk("skid_pop_b", {32'b0, result_o}, 64'h40400000);
    chk("skid_rdy", {63'b0, in_ready}, 64'd1);
    drive(1, 32'h40800000, 5'b0, 1, 4'd3); cycle();
    chk("skid_c", {32'b0, result_o}, 64'h40800000);
    drive(0, '0, '0, 0, '0); cycle();

    // Flags
    clear = 1; cycle(); clear = 0;
    drive(1, 32'h1, 5'b00001, 0, 4'd4); cycle();
    drive(1, 32'h2, 5'b00100, 0, 4'd5); cycle();
    drive(0, '0, '0, 0, '0); cycle();
    chk("flags_or", {59'b0, fflags}, 64'b00101);
    drive(1, 32'h3, 5'b10000, 0, 4'd6); cycle();
    drive(0, '0, '0, 0, '0); clear = 1; cycle(); clear = 0;
    chk("flags_clr_pop", {59'b0, fflags}, 64'b10000);

    // Flush in FULL with push and pop
    out_ready = 0;
    drive(1, 32'hAAAA0001, 5'b01000, 0, 4'd7); cycle();
    drive(1, 32'hAAAA0002, 5'b01000, 0, 4'd8); cycle();
    drive(1, 32'hAAAA0003, 5'b01000, 0, 4'd9); out_ready = 1; flush = 1; cycle();
    flush = 0; drive(0, '0, '0, 0, '0);
    chk("flush_valid", {63'b0, out_valid}, 64'd0);
    chk("flush_busy", {63'b0, busy}, 64'd0);
    chk("flush_flags", {59'b0, fflags}, 64'b10000);
    repeat (3) cycle();

    // Reset mid-operation
    drive(1, 32'h5, 5'b11111, 0, 4'd10); cycle();
    drive(0, '0, '0, 0, '0); cycle();
    out_ready = 0;
    drive(1, 32'h6, 5'b0, 0, 4'd11); cycle();
    drive(1, 32'h7, 5'b0, 0, 4'd12); cycle();
    drive(0, '0, '0, 0, '0);
    chk("pre_rst_flags", {59'b0, fflags}, 64'b11111);
    rst = 1; #1;
    chk("rst_mid_rdy", {63'b0, in_ready}, 64'd0);
    cycle();
    rst = 0; #1;
    chk("rst_mid_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_mid_flags", {59'b0, fflags}, 64'd0);
    chk("rst_mid_rdy_after", {63'b0, in_ready}, 64'd1);

    // Random traffic
    for (int n = 0; n < 10000; n++) begin
      drive($urandom_range(0, 1), $urandom, 5'($urandom), 1'($urandom), tag_t'($urandom));
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      clear     = ($urandom_range(0, 49) == 0);
      cycle();
    end
    drive(0, '0, '0, 0, '0); flush = 0; clear = 0; out_ready = 1;
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
